alu_iterative_exec: RTL and testbench

//  Execution unit that consumes the 4-bit Operation code produced by ALU control and computes the

---
 rtl/alu_iterative_exec.sv | 152 +++++++++++++++
 tb/tb_alu_iterative_exec.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/alu_iterative_exec.sv
// Execution unit: single-cycle logic/arith/compare/branch ops plus a 1-bit-per-cycle
// iterative shifter, with valid/ready handshakes on both the operand and result sides.
module alu_iterative_exec #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             illegal
);

  localparam int SHAMT_W = $clog2(WIDTH);

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0011;
  localparam logic [3:0] OP_SLL = 4'b0100;
  localparam logic [3:0] OP_SRL = 4'b0101;
  localparam logic [3:0] OP_XOR = 4'b0110;
  localparam logic [3:0] OP_SRA = 4'b0111;
  localparam logic [3:0] OP_BEQ = 4'b1000;
  localparam logic [3:0] OP_BNE = 4'b1001;
  localparam logic [3:0] OP_BLT = 4'b1010;
  localparam logic [3:0] OP_SLT = 4'b1100;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_DONE
  } state_t;

  state_t               state, state_next;
  logic [3:0]           op_q;
  logic [WIDTH-1:0]     acc;
  logic [SHAMT_W-1:0]   cnt;

  logic                 accept;
  logic                 is_shift;
  logic [SHAMT_W-1:0]   shamt;
  logic                 signed_lt;
  logic [WIDTH-1:0]     alu_result;
  logic                 alu_illegal;
  logic [WIDTH-1:0]     shift_step;
  logic                 shift_last;

  assign in_ready   = (state == S_IDLE);
  assign out_valid  = (state == S_DONE);
  assign accept     = in_valid && in_ready;
  assign shamt      = b[SHAMT_W-1:0];
  assign is_shift   = (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA);
  assign signed_lt  = $signed(a) < $signed(b);
  assign shift_last = (cnt == SHAMT_W'(1));

  // Single-cycle datapath; shift ops only land here when shamt == 0, giving a pass-through.
  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    alu_result  = '0;
    alu_illegal = 1'b0;
    case (op)
      OP_AND:                 alu_result = a & b;
      OP_OR:                  alu_result = a | b;
      OP_XOR:                 alu_result = a ^ b;
      OP_ADD:                 alu_result = a + b;
      OP_SUB:                 alu_result = a - b;
      OP_SLL, OP_SRL, OP_SRA: alu_result = a;
      OP_SLT:                 alu_result = {{(WIDTH-1){1'b0}}, signed_lt};
      OP_BEQ:                 alu_result = {{(WIDTH-1){1'b0}}, (a == b)};
      OP_BNE:                 alu_result = {{(WIDTH-1){1'b0}}, (a != b)};
      OP_BLT:                 alu_result = {{(WIDTH-1){1'b0}}, signed_lt};
      default:                alu_illegal = 1'b1;
    endcase
  end

  always_comb begin
    case (op_q)
      OP_SLL:  shift_step = {acc[WIDTH-2:0], 1'b0};
      OP_SRL:  shift_step = {1'b0, acc[WIDTH-1:1]};
      default: shift_step = {acc[WIDTH-1], acc[WIDTH-1:1]};
    endcase
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: begin
        if (accept) begin
          state_next = (is_shift && (shamt != '0)) ? S_SHIFT : S_DONE;
        end
      end
      S_SHIFT: if (shift_last) state_next = S_DONE;
      S_DONE:  if (out_ready)  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // NOTE: datapath registers are reset too, so an aborted op leaves result=0/zero=1 immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q    <= '0;
      acc     <= '0;
      cnt     <= '0;
      result  <= '0;
      zero    <= 1'b1;
      illegal <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            op_q <= op;
            if (is_shift && (shamt != '0)) begin
              acc     <= a;
              cnt     <= shamt;
              illegal <= 1'b0;
            end else begin
              result  <= alu_result;
              zero    <= (alu_result == '0);
              illegal <= alu_illegal;
            end
          end
        end
        S_SHIFT: begin
          acc <= shift_step;
          cnt <= cnt - SHAMT_W'(1);
          if (shift_last) begin
            result <= shift_step;
            zero   <= (shift_step == '0);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_iterative_exec.sv
// Directed-vector bench for alu_iterative_exec: results, flags, latency, backpressure,
// mid-shift reset abort and illegal-op handling, all against hand-computed values.
module tb_alu_iterative_exec;

  localparam int WIDTH = 32;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             illegal;

  int n_vec = 0;
  int n_err = 0;

  alu_iterative_exec #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .zero      (zero),
    .illegal   (illegal)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Present one op for the accept edge, then scramble the operand bus.
  task automatic start(input logic [3:0] o, input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
    int guard = 0;
    while (!in_ready && guard < 100) begin
      @(posedge clk); #1;
      guard++;
    end
    if (!in_ready) check("start_ready_timeout", in_ready, 1'b1);
    in_valid = 1'b1;
    op = o;
    a  = x;
    b  = y;
    @(posedge clk); #1;
    in_valid = 1'b0;
    op = 4'($urandom);
    a  = $urandom;
    b  = $urandom;
  endtask

  // Latency counts edges after the accept edge until out_valid is seen.
  task automatic wait_result(output int lat, output bit busy_ok);
    lat = 0;
    busy_ok = 1'b1;
    while (!out_valid && lat < 100) begin
      if (in_ready) busy_ok = 1'b0;
      @(posedge clk); #1;
      lat++;
    end
    if (!out_valid) check("result_timeout", out_valid, 1'b1);
  endtask

  task automatic handshake(input string tag);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, "_released"}, out_valid, 1'b0);
    check({tag, "_idle"}, in_ready, 1'b1);
  endtask

  task automatic run(input string tag, input logic [3:0] o, input logic [WIDTH-1:0] x,
                     input logic [WIDTH-1:0] y, input logic [WIDTH-1:0] exp_res,
                     input logic exp_ill, input int exp_lat);
    int lat;
    bit busy_ok;
    start(o, x, y);
    wait_result(lat, busy_ok);
    check({tag, "_res"}, result, exp_res);
    check({tag, "_zero"}, zero, (exp_res == '0));
    check({tag, "_ill"}, illegal, exp_ill);
    check({tag, "_lat"}, lat, exp_lat);
    check({tag, "_busy"}, in_ready, 1'b0);
    if (exp_lat > 0) check({tag, "_shift_ready"}, busy_ok, 1'b1);
    handshake(tag);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    bit busy_ok;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    op = '0;
    a  = '0;
    b  = '0;
    #22;
    check("rst_result", result, 32'h0);
    check("rst_zero", zero, 1'b1);
    check("rst_illegal", illegal, 1'b0);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_in_ready", in_ready, 1'b1);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Single-cycle ops
    run("add_ovf", 4'b0010, 32'h7FFF_FFFF, 32'h1,         32'h8000_0000, 1'b0, 0);
    run("sub_eq",  4'b0011, 32'h5,         32'h5,         32'h0,         1'b0, 0);
    run("sub_wrap",4'b0011, 32'h0,         32'h1,         32'hFFFF_FFFF, 1'b0, 0);
    run("bne_eq",  4'b1001, 32'h5,         32'h5,         32'h0,         1'b0, 0);
    run("blt_neg", 4'b1010, 32'hFFFF_FFFF, 32'h1,         32'h1,         1'b0, 0);
    run("beq_eq",  4'b1000, 32'h3,         32'h3,         32'h1,         1'b0, 0);
    run("slt_neg", 4'b1100, 32'hFFFF_FFFF, 32'h0,         32'h1,         1'b0, 0);
    run("slt_pos", 4'b1100, 32'h7,         32'h2,         32'h0,         1'b0, 0);
    run("and",     4'b0000, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'h00F0_00F0, 1'b0, 0);
    run("or",      4'b0001, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'hFFF0_FFF0, 1'b0, 0);
    run("xor",     4'b0110, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'hFF00_FF00, 1'b0, 0);

    // Iterative shifts: latency equals shift amount; shamt 0 bypasses SHIFT
    run("sra31",   4'b0111, 32'h8000_0000, 32'd31,        32'hFFFF_FFFF, 1'b0, 31);
    run("srl31",   4'b0101, 32'h8000_0000, 32'd31,        32'h0000_0001, 1'b0, 31);
    run("sll4",    4'b0100, 32'h1234_5678, 32'hFFFF_FFE4, 32'h2345_6780, 1'b0, 4);
    run("sll0",    4'b0100, 32'h1234_5678, 32'h20,        32'h1234_5678, 1'b0, 0);

    // Backpressure: result held, concurrent in_valid ignored
    start(4'b0010, 32'd2, 32'd3);
    wait_result(lat, busy_ok);
    in_valid = 1'b1;
    op = 4'b0010;
    a  = 32'd100;
    b  = 32'd100;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("bp_valid", out_valid, 1'b1);
      check("bp_result", result, 32'd5);
      check("bp_in_ready", in_ready, 1'b0);
    end
    in_valid = 1'b0;
    handshake("bp");
    run("after_bp", 4'b0010, 32'd1, 32'd1, 32'd2, 1'b0, 0);

    // Reset during SHIFT with 10 steps remaining
    start(4'b0100, 32'h1, 32'd20);
    repeat (10) begin
      @(posedge clk); #1;
    end
    check("mid_shift_busy", in_ready, 1'b0);
    rst_n = 1'b0;
    #1;
    check("abort_out_valid", out_valid, 1'b0);
    check("abort_result", result, 32'h0);
    check("abort_zero", zero, 1'b1);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("abort_in_ready", in_ready, 1'b1);
    check("abort_no_result", out_valid, 1'b0);

    run("illegal", 4'b1111, 32'h1234, 32'h5678, 32'h0, 1'b1, 0);
    run("clr_ill", 4'b0010, 32'd4,    32'd5,    32'd9, 1'b0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
